// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with valid/ready in (a, b, cin) and out (sum, cout), busy during SHIFT
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic s, c_next;
  assign s = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign in_ready = state_q == IDLE;
  assign busy = state_q == SHIFT;
  assign out_valid = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    cout_d = cout_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        carry_d = cin;
        cnt_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        sum_d = sum_q >> 1;
        sum_d[WIDTH-1] = s;
        carry_d = c_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d = c_next;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
